// File: rtl/exu_pkg.sv
// -----------------------------------------------------------------------------
// exu_pkg
// Shared definitions for the SwitchMCU execution unit:
//   - LSU access-size encodings (byte / half / word)
//   - ALU operation enum used between exu_top_swc and exu_alu
//   - sign-extension helper for the 12-bit immediates
// -----------------------------------------------------------------------------
package exu_pkg;

   localparam logic [1:0] SizeB = 2'd0;
   localparam logic [1:0] SizeH = 2'd1;
   localparam logic [1:0] SizeW = 2'd2;

   typedef enum logic [3:0] {
      AluAdd,
      AluSub,
      AluSll,
      AluSlt,
      AluSltu,
      AluXor,
      AluSrl,
      AluSra,
      AluOr,
      AluAnd,
      AluEq,
      AluNe,
      AluLt,
      AluGe,
      AluLtu,
      AluGeu
   } alu_op_e;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/exu_alu.sv
// -----------------------------------------------------------------------------
// exu_alu
// Combinational RV32I ALU and branch comparator.
// Ports:
//   i_op1    : first operand (rs1)
//   i_op2    : second operand (rs2 or sign-extended immediate)
//   i_op     : operation select (alu_op_e)
//   o_result : 32-bit arithmetic/logic result
//   o_taken  : branch condition result for the compare operations
// -----------------------------------------------------------------------------
module exu_alu
   import exu_pkg::*;
(
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   input  alu_op_e     i_op,
   output logic [31:0] o_result,
   output logic        o_taken
);

   logic       w_lt;
   logic       w_ltu;
   logic       w_eq;
   logic [4:0] w_shamt;

   assign w_lt    = $signed(i_op1) < $signed(i_op2);
   assign w_ltu   = i_op1 < i_op2;
   assign w_eq    = i_op1 == i_op2;
   // Only the low five bits count, for both register and immediate shifts.
   assign w_shamt = i_op2[4:0];

   always_comb begin
      o_result = '0;
      o_taken  = 1'b0;
      case (i_op)
         AluAdd:  o_result = i_op1 + i_op2;
         AluSub:  o_result = i_op1 - i_op2;
         AluSll:  o_result = i_op1 << w_shamt;
         AluSlt:  o_result = {31'b0, w_lt};
         AluSltu: o_result = {31'b0, w_ltu};
         AluXor:  o_result = i_op1 ^ i_op2;
         AluSrl:  o_result = i_op1 >> w_shamt;
         AluSra:  o_result = $unsigned($signed(i_op1) >>> w_shamt);
         AluOr:   o_result = i_op1 | i_op2;
         AluAnd:  o_result = i_op1 & i_op2;
         AluEq:   o_taken  = w_eq;
         AluNe:   o_taken  = !w_eq;
         AluLt:   o_taken  = w_lt;
         AluGe:   o_taken  = !w_lt;
         AluLtu:  o_taken  = w_ltu;
         AluGeu:  o_taken  = !w_ltu;
         default: ;
      endcase
   end

endmodule

// File: rtl/exu_top_swc.sv
// -----------------------------------------------------------------------------
// exu_top_swc
// Four-phase RV32I execution unit. Phase 0 reads rs1, phase 1 latches op1 and
// reads rs2, phase 2 latches op2, phase 3 executes and emits single-cycle
// write-back / PC-redirect / load / store requests.
// Ports:
//   hclk, hrstn            : clock, async active-low reset
//   inst_in, dec_*         : instruction and one-hot decode from the decoder
//   pc, cycle_cnt          : PC of the instruction, phase from the controller
//   reg_raddr_1/ren_1/rdata_1 : shared register-file read port
//   reg_raddr_2/ren_2/rdata_2 : rs2 index, rs2-needed flag, latched rs2 value
//   reg_waddr/wdata/wen    : write-back
//   pc_write/pc_wdata      : redirect request
//   exu_load_*, exu_store_*: LSU requests
//   inst_out               : instruction latched in phase 0
//   ifu_dec_stall          : holds IFU/decoder during phases 0..2
// -----------------------------------------------------------------------------
module exu_top_swc
   import exu_pkg::*;
(
   input  logic        hclk,
   input  logic        hrstn,
   input  logic [31:0] inst_in,
   input  logic        dec_lui,
   input  logic        dec_auipc,
   input  logic        dec_jal,
   input  logic        dec_jalr,
   input  logic        dec_beq,
   input  logic        dec_bne,
   input  logic        dec_blt,
   input  logic        dec_bge,
   input  logic        dec_bltu,
   input  logic        dec_bgeu,
   input  logic        dec_lb,
   input  logic        dec_lh,
   input  logic        dec_lw,
   input  logic        dec_lbu,
   input  logic        dec_lhu,
   input  logic        dec_sb,
   input  logic        dec_sh,
   input  logic        dec_sw,
   input  logic        dec_addi,
   input  logic        dec_slti,
   input  logic        dec_sltiu,
   input  logic        dec_xori,
   input  logic        dec_ori,
   input  logic        dec_andi,
   input  logic        dec_slli,
   input  logic        dec_srli,
   input  logic        dec_srai,
   input  logic        dec_add,
   input  logic        dec_sub,
   input  logic        dec_sll,
   input  logic        dec_slt,
   input  logic        dec_sltu,
   input  logic        dec_xor,
   input  logic        dec_srl,
   input  logic        dec_sra,
   input  logic        dec_or,
   input  logic        dec_and,
   input  logic        dec_fence,
   input  logic        dec_fence_i,
   input  logic        dec_ecall,
   input  logic        dec_ebreak,
   input  logic        dec_csrrw,
   input  logic        dec_csrrs,
   input  logic        dec_csrrc,
   input  logic        dec_csrrwi,
   input  logic        dec_csrrsi,
   input  logic        dec_csrrci,
   input  logic        dec_upper_en,
   input  logic        dec_imm_en,
   input  logic        dec_reg_en,
   input  logic        dec_jump_en,
   input  logic        dec_branch_en,
   input  logic        dec_load_en,
   input  logic        dec_store_en,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   input  logic [11:0] dec_imm_type_i,
   input  logic [11:0] dec_imm_type_s,
   input  logic [12:0] dec_imm_type_b,
   input  logic [19:0] dec_imm_type_u,
   input  logic [20:0] dec_imm_type_j,
   input  logic [31:0] pc,
   input  logic [31:0] reg_rdata_1,
   input  logic [3:0]  cycle_cnt,
   output logic [31:0] inst_out,
   output logic        pc_write,
   output logic [31:0] pc_wdata,
   output logic [4:0]  exu_load_rd,
   output logic [31:0] exu_load_base_addr,
   output logic [31:0] exu_load_offset,
   output logic        exu_load_sext,
   output logic [1:0]  exu_load_size,
   output logic        exu_load_en,
   output logic [31:0] exu_store_addr,
   output logic [31:0] exu_store_data,
   output logic [1:0]  exu_store_size,
   output logic        exu_store_en,
   output logic [4:0]  reg_waddr,
   output logic [31:0] reg_wdata,
   output logic        reg_wen,
   output logic [4:0]  reg_raddr_1,
   output logic        reg_ren_1,
   output logic [4:0]  reg_raddr_2,
   output logic        reg_ren_2,
   output logic [31:0] reg_rdata_2,
   output logic        ifu_dec_stall
);

   // ---------------------------------------------------------------------------
   // Decode grouping
   // ---------------------------------------------------------------------------
   logic w_alu_imm;
   logic w_alu_reg;
   logic w_branch;
   logic w_load;
   logic w_store;
   logic w_sys;
   logic w_valid;
   logic w_uses_rs1;
   logic w_uses_rs2;

   assign w_alu_imm = dec_addi | dec_slti | dec_sltiu | dec_xori | dec_ori | dec_andi |
                      dec_slli | dec_srli | dec_srai;
   assign w_alu_reg = dec_add | dec_sub | dec_sll | dec_slt | dec_sltu | dec_xor |
                      dec_srl | dec_sra | dec_or | dec_and;
   assign w_branch  = dec_beq | dec_bne | dec_blt | dec_bge | dec_bltu | dec_bgeu;
   assign w_load    = dec_lb | dec_lh | dec_lw | dec_lbu | dec_lhu;
   assign w_store   = dec_sb | dec_sh | dec_sw;
   assign w_sys     = dec_fence | dec_fence_i | dec_ecall | dec_ebreak | dec_csrrw |
                      dec_csrrs | dec_csrrc | dec_csrrwi | dec_csrrsi | dec_csrrci;
   assign w_valid   = w_alu_imm | w_alu_reg | dec_lui | dec_auipc | dec_jal | dec_jalr |
                      w_branch | w_load | w_store | w_sys;

   assign w_uses_rs1 = w_alu_imm | w_alu_reg | dec_jalr | w_branch | w_load | w_store;
   assign w_uses_rs2 = w_alu_reg | w_branch | w_store;

   // Class flags are redundant with the one-hot strobes, which are used instead.
   logic w_unused_class;
   assign w_unused_class = ^{dec_upper_en, dec_imm_en, dec_reg_en, dec_jump_en,
                             dec_branch_en, dec_load_en, dec_store_en};

   // ---------------------------------------------------------------------------
   // Immediates
   // ---------------------------------------------------------------------------
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;

   assign w_imm_i = sext12(dec_imm_type_i);
   assign w_imm_s = sext12(dec_imm_type_s);
   assign w_imm_b = {{19{dec_imm_type_b[12]}}, dec_imm_type_b};
   assign w_imm_u = {dec_imm_type_u, 12'b0};
   assign w_imm_j = {{11{dec_imm_type_j[20]}}, dec_imm_type_j};

   // ---------------------------------------------------------------------------
   // Phase registers
   // ---------------------------------------------------------------------------
   logic [31:0] r_inst;
   logic [31:0] r_op1;
   logic [31:0] r_op2;
   // Set when phase 0 saw a valid op; a reset in between drops it so the
   // aborted instruction never reaches phase 3 with live strobes.
   logic        r_run;

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_inst <= '0;
         r_op1  <= '0;
         r_op2  <= '0;
         r_run  <= 1'b0;
      end else begin
         case (cycle_cnt)
            4'd0: begin
               r_inst <= inst_in;
               r_run  <= w_valid;
            end
            4'd1:    r_op1 <= reg_rdata_1;
            4'd2:    r_op2 <= reg_rdata_1;
            default: r_run <= 1'b0;
         endcase
      end
   end

   assign inst_out    = r_inst;
   assign reg_rdata_2 = r_op2;

   // ---------------------------------------------------------------------------
   // Register-file read port and stall
   // ---------------------------------------------------------------------------
   always_comb begin
      reg_raddr_1 = '0;
      reg_ren_1   = 1'b0;
      if (cycle_cnt == 4'd0) begin
         reg_raddr_1 = dec_rs1;
         reg_ren_1   = w_uses_rs1;
      end else if (cycle_cnt == 4'd1) begin
         reg_raddr_1 = dec_rs2;
         reg_ren_1   = w_uses_rs2;
      end
   end

   assign reg_raddr_2   = dec_rs2;
   assign reg_ren_2     = w_uses_rs2;
   assign ifu_dec_stall = w_valid && (cycle_cnt < 4'd3);

   // ---------------------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------------------
   alu_op_e     w_alu_op;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_res;
   logic        w_alu_taken;

   always_comb begin
      w_alu_op = AluAdd;
      if (dec_sub)                    w_alu_op = AluSub;
      else if (dec_sll  | dec_slli)   w_alu_op = AluSll;
      else if (dec_slt  | dec_slti)   w_alu_op = AluSlt;
      else if (dec_sltu | dec_sltiu)  w_alu_op = AluSltu;
      else if (dec_xor  | dec_xori)   w_alu_op = AluXor;
      else if (dec_srl  | dec_srli)   w_alu_op = AluSrl;
      else if (dec_sra  | dec_srai)   w_alu_op = AluSra;
      else if (dec_or   | dec_ori)    w_alu_op = AluOr;
      else if (dec_and  | dec_andi)   w_alu_op = AluAnd;
      else if (dec_beq)               w_alu_op = AluEq;
      else if (dec_bne)               w_alu_op = AluNe;
      else if (dec_blt)               w_alu_op = AluLt;
      else if (dec_bge)               w_alu_op = AluGe;
      else if (dec_bltu)              w_alu_op = AluLtu;
      else if (dec_bgeu)              w_alu_op = AluGeu;
   end

   assign w_alu_b = w_alu_imm ? w_imm_i : r_op2;

   exu_alu u_alu (
      .i_op1    (r_op1),
      .i_op2    (w_alu_b),
      .i_op     (w_alu_op),
      .o_result (w_alu_res),
      .o_taken  (w_alu_taken)
   );

   // ---------------------------------------------------------------------------
   // Execute (phase 3)
   // ---------------------------------------------------------------------------
   logic        w_exec;
   logic        w_wen_req;
   logic [31:0] w_wdata;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_jalr_sum;

   assign w_exec     = (cycle_cnt == 4'd3) && r_run && w_valid;
   assign w_pc_plus4 = pc + 32'd4;
   assign w_jalr_sum = r_op1 + w_imm_i;

   always_comb begin
      pc_write           = 1'b0;
      pc_wdata           = '0;
      exu_load_rd        = '0;
      exu_load_base_addr = '0;
      exu_load_offset    = '0;
      exu_load_sext      = 1'b0;
      exu_load_size      = SizeB;
      exu_load_en        = 1'b0;
      exu_store_addr     = '0;
      exu_store_data     = '0;
      exu_store_size     = SizeB;
      exu_store_en       = 1'b0;
      w_wen_req          = 1'b0;
      w_wdata            = '0;
      if (w_exec) begin
         if (w_alu_imm || w_alu_reg) begin
            w_wen_req = 1'b1;
            w_wdata   = w_alu_res;
         end
         if (dec_lui) begin
            w_wen_req = 1'b1;
            w_wdata   = w_imm_u;
         end
         if (dec_auipc) begin
            w_wen_req = 1'b1;
            w_wdata   = pc + w_imm_u;
         end
         if (dec_jal) begin
            pc_write  = 1'b1;
            pc_wdata  = pc + w_imm_j;
            w_wen_req = 1'b1;
            w_wdata   = w_pc_plus4;
         end
         if (dec_jalr) begin
            pc_write  = 1'b1;
            pc_wdata  = {w_jalr_sum[31:1], 1'b0};
            w_wen_req = 1'b1;
            w_wdata   = w_pc_plus4;
         end
         if (w_branch && w_alu_taken) begin
            pc_write = 1'b1;
            pc_wdata = pc + w_imm_b;
         end
         if (w_load) begin
            exu_load_en        = 1'b1;
            exu_load_rd        = dec_rd;
            exu_load_base_addr = r_op1;
            exu_load_offset    = w_imm_i;
            exu_load_sext      = dec_lb | dec_lh;
            exu_load_size      = (dec_lb | dec_lbu) ? SizeB :
                                 (dec_lh | dec_lhu) ? SizeH : SizeW;
         end
         if (w_store) begin
            exu_store_en   = 1'b1;
            exu_store_addr = r_op1 + w_imm_s;
            exu_store_data = r_op2;
            exu_store_size = dec_sb ? SizeB : dec_sh ? SizeH : SizeW;
         end
      end
   end

   // x0 is never written.
   assign reg_wen   = w_wen_req && (dec_rd != 5'd0);
   assign reg_waddr = reg_wen ? dec_rd : 5'd0;
   assign reg_wdata = reg_wen ? w_wdata : 32'd0;

endmodule

// File: tb/tb_exu_top_swc.sv
module tb_exu_top_swc;

   localparam int OpLui = 0, OpAuipc = 1, OpJal = 2, OpJalr = 3, OpBeq = 4, OpBne = 5,
                  OpBlt = 6, OpBltu = 8, OpLh = 11, OpLbu = 13, OpSb = 15, OpSw = 17,
                  OpAddi = 18, OpSrai = 26, OpSub = 28, OpSll = 29, OpSlt = 30,
                  OpSltu = 31, OpEcall = 39;

   typedef struct packed {
      logic        pcw;
      logic [31:0] pcd;
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ld_en;
      logic [4:0]  ld_rd;
      logic [31:0] ld_base;
      logic [31:0] ld_off;
      logic        ld_sext;
      logic [1:0]  ld_size;
      logic        st_en;
      logic [31:0] st_addr;
      logic [31:0] st_data;
      logic [1:0]  st_size;
   } exp_t;

   logic        hclk = 1'b0;
   logic        hrstn;
   logic [31:0] inst_in;
   logic [46:0] dec_v;
   logic        c_upper, c_imm, c_reg, c_jump, c_branch, c_load, c_store;
   logic [4:0]  rs1, rs2, rd;
   logic [11:0] imm_i, imm_s;
   logic [12:0] imm_b;
   logic [19:0] imm_u;
   logic [20:0] imm_j;
   logic [31:0] pc_v;
   logic [31:0] reg_rdata_1;
   logic [3:0]  cycle_cnt;

   logic [31:0] inst_out, pc_wdata, exu_load_base_addr, exu_load_offset;
   logic [31:0] exu_store_addr, exu_store_data, reg_wdata, reg_rdata_2;
   logic [4:0]  exu_load_rd, reg_waddr, reg_raddr_1, reg_raddr_2;
   logic [1:0]  exu_load_size, exu_store_size;
   logic        pc_write, exu_load_sext, exu_load_en, exu_store_en, reg_wen;
   logic        reg_ren_1, reg_ren_2, ifu_dec_stall;

   logic [31:0] regs [32];
   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          cur_op;

   always #5 hclk = ~hclk;

   exu_top_swc dut (
      .hclk(hclk), .hrstn(hrstn), .inst_in(inst_in),
      .dec_lui(dec_v[0]), .dec_auipc(dec_v[1]), .dec_jal(dec_v[2]), .dec_jalr(dec_v[3]),
      .dec_beq(dec_v[4]), .dec_bne(dec_v[5]), .dec_blt(dec_v[6]), .dec_bge(dec_v[7]),
      .dec_bltu(dec_v[8]), .dec_bgeu(dec_v[9]), .dec_lb(dec_v[10]), .dec_lh(dec_v[11]),
      .dec_lw(dec_v[12]), .dec_lbu(dec_v[13]), .dec_lhu(dec_v[14]), .dec_sb(dec_v[15]),
      .dec_sh(dec_v[16]), .dec_sw(dec_v[17]), .dec_addi(dec_v[18]), .dec_slti(dec_v[19]),
      .dec_sltiu(dec_v[20]), .dec_xori(dec_v[21]), .dec_ori(dec_v[22]),
      .dec_andi(dec_v[23]), .dec_slli(dec_v[24]), .dec_srli(dec_v[25]),
      .dec_srai(dec_v[26]), .dec_add(dec_v[27]), .dec_sub(dec_v[28]), .dec_sll(dec_v[29]),
      .dec_slt(dec_v[30]), .dec_sltu(dec_v[31]), .dec_xor(dec_v[32]), .dec_srl(dec_v[33]),
      .dec_sra(dec_v[34]), .dec_or(dec_v[35]), .dec_and(dec_v[36]), .dec_fence(dec_v[37]),
      .dec_fence_i(dec_v[38]), .dec_ecall(dec_v[39]), .dec_ebreak(dec_v[40]),
      .dec_csrrw(dec_v[41]), .dec_csrrs(dec_v[42]), .dec_csrrc(dec_v[43]),
      .dec_csrrwi(dec_v[44]), .dec_csrrsi(dec_v[45]), .dec_csrrci(dec_v[46]),
      .dec_upper_en(c_upper), .dec_imm_en(c_imm), .dec_reg_en(c_reg),
      .dec_jump_en(c_jump), .dec_branch_en(c_branch), .dec_load_en(c_load),
      .dec_store_en(c_store), .dec_rs1(rs1), .dec_rs2(rs2), .dec_rd(rd),
      .dec_imm_type_i(imm_i), .dec_imm_type_s(imm_s), .dec_imm_type_b(imm_b),
      .dec_imm_type_u(imm_u), .dec_imm_type_j(imm_j), .pc(pc_v),
      .reg_rdata_1(reg_rdata_1), .cycle_cnt(cycle_cnt), .inst_out(inst_out),
      .pc_write(pc_write), .pc_wdata(pc_wdata), .exu_load_rd(exu_load_rd),
      .exu_load_base_addr(exu_load_base_addr), .exu_load_offset(exu_load_offset),
      .exu_load_sext(exu_load_sext), .exu_load_size(exu_load_size),
      .exu_load_en(exu_load_en), .exu_store_addr(exu_store_addr),
      .exu_store_data(exu_store_data), .exu_store_size(exu_store_size),
      .exu_store_en(exu_store_en), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .reg_wen(reg_wen), .reg_raddr_1(reg_raddr_1), .reg_ren_1(reg_ren_1),
      .reg_raddr_2(reg_raddr_2), .reg_ren_2(reg_ren_2), .reg_rdata_2(reg_rdata_2),
      .ifu_dec_stall(ifu_dec_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic uses1(input int o);
      return (o == OpJalr) || (o >= 4 && o <= 36);
   endfunction

   function automatic logic uses2(input int o);
      return (o >= 4 && o <= 9) || (o >= 15 && o <= 17) || (o >= 27 && o <= 36);
   endfunction

   function automatic exp_t ex_none();
      exp_t e;
      e = '0;
      return e;
   endfunction

   function automatic exp_t ex_wb(input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e = '0;
      e.wen = 1'b1;
      e.wa  = a;
      e.wd  = d;
      return e;
   endfunction

   function automatic exp_t ex_pc(input logic [31:0] p);
      exp_t e;
      e = '0;
      e.pcw = 1'b1;
      e.pcd = p;
      return e;
   endfunction

   task automatic set_op(input int o, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] p);
      cur_op   = o;
      dec_v    = '0;
      dec_v[o] = 1'b1;
      c_upper  = (o <= 1);
      c_jump   = (o == 2 || o == 3);
      c_branch = (o >= 4 && o <= 9);
      c_load   = (o >= 10 && o <= 14);
      c_store  = (o >= 15 && o <= 17);
      c_imm    = (o >= 18 && o <= 26);
      c_reg    = (o >= 27 && o <= 36);
      rs1 = s1; rs2 = s2; rd = d; pc_v = p;
      imm_i = '0; imm_s = '0; imm_b = '0; imm_u = '0; imm_j = '0;
      inst_in = $urandom;
   endtask

   // Runs phases 0..3 plus one idle phase; optional reset pulse in phase 2.
   task automatic run_instr(input string tag, input exp_t e, input bit mid_reset);
      logic [4:0]  idx;
      logic        ren;
      logic [31:0] inst_v;
      exp_t        x;
      sb_q.push_back(e);
      inst_v = inst_in;
      @(negedge hclk);
      cycle_cnt   = 4'd0;
      reg_rdata_1 = 32'hDEADBEEF;
      #1;
      chk({tag, ".p0_raddr"}, {27'b0, reg_raddr_1}, {27'b0, rs1});
      chk({tag, ".p0_ren"}, {31'b0, reg_ren_1}, {31'b0, uses1(cur_op)});
      chk({tag, ".p0_stall"}, {31'b0, ifu_dec_stall}, 32'd1);
      idx = reg_raddr_1;
      ren = reg_ren_1;
      @(negedge hclk);
      cycle_cnt   = 4'd1;
      reg_rdata_1 = ren ? regs[idx] : 32'hDEADBEEF;
      #1;
      chk({tag, ".inst_out"}, inst_out, inst_v);
      chk({tag, ".p1_raddr"}, {27'b0, reg_raddr_1}, {27'b0, rs2});
      chk({tag, ".p1_ren"}, {31'b0, reg_ren_1}, {31'b0, uses2(cur_op)});
      chk({tag, ".p1_stall"}, {31'b0, ifu_dec_stall}, 32'd1);
      idx = reg_raddr_1;
      ren = reg_ren_1;
      @(negedge hclk);
      cycle_cnt   = 4'd2;
      reg_rdata_1 = ren ? regs[idx] : 32'hDEADBEEF;
      #1;
      chk({tag, ".p2_stall"}, {31'b0, ifu_dec_stall}, 32'd1);
      if (mid_reset) begin
         hrstn = 1'b0;
         #1;
         chk({tag, ".rst_inst_out"}, inst_out, 32'd0);
         hrstn = 1'b1;
      end
      @(negedge hclk);
      cycle_cnt   = 4'd3;
      reg_rdata_1 = 32'hDEADBEEF;
      #1;
      x = sb_q.pop_front();
      chk({tag, ".p3_stall"}, {31'b0, ifu_dec_stall}, 32'd0);
      chk({tag, ".pc_write"}, {31'b0, pc_write}, {31'b0, x.pcw});
      chk({tag, ".pc_wdata"}, pc_wdata, x.pcd);
      chk({tag, ".reg_wen"}, {31'b0, reg_wen}, {31'b0, x.wen});
      chk({tag, ".reg_waddr"}, {27'b0, reg_waddr}, {27'b0, x.wa});
      chk({tag, ".reg_wdata"}, reg_wdata, x.wd);
      chk({tag, ".ld_en"}, {31'b0, exu_load_en}, {31'b0, x.ld_en});
      chk({tag, ".ld_rd"}, {27'b0, exu_load_rd}, {27'b0, x.ld_rd});
      chk({tag, ".ld_base"}, exu_load_base_addr, x.ld_base);
      chk({tag, ".ld_off"}, exu_load_offset, x.ld_off);
      chk({tag, ".ld_sext"}, {31'b0, exu_load_sext}, {31'b0, x.ld_sext});
      chk({tag, ".ld_size"}, {30'b0, exu_load_size}, {30'b0, x.ld_size});
      chk({tag, ".st_en"}, {31'b0, exu_store_en}, {31'b0, x.st_en});
      chk({tag, ".st_addr"}, exu_store_addr, x.st_addr);
      chk({tag, ".st_data"}, exu_store_data, x.st_data);
      chk({tag, ".st_size"}, {30'b0, exu_store_size}, {30'b0, x.st_size});
      if (uses2(cur_op))
         chk({tag, ".rdata_2"}, reg_rdata_2, regs[rs2]);
      @(negedge hclk);
      cycle_cnt = 4'd4;
      #1;
      chk({tag, ".idle_strobes"}, {28'b0, pc_write, reg_wen, exu_load_en, exu_store_en},
          32'd0);
      chk({tag, ".idle_stall"}, {31'b0, ifu_dec_stall}, 32'd0);
   endtask

   initial begin
      exp_t e;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      hrstn = 1'b0;
      cycle_cnt = 4'd4;
      reg_rdata_1 = 32'h0;
      set_op(OpAddi, 5'd0, 5'd0, 5'd0, 32'h0);
      dec_v = '0;
      c_imm = 1'b0;
      inst_in = 32'h12345678;
      repeat (2) @(posedge hclk);
      #1;
      chk("rst.inst_out", inst_out, 32'd0);
      chk("rst.strobes", {28'b0, pc_write, reg_wen, exu_load_en, exu_store_en}, 32'd0);
      chk("rst.stall", {31'b0, ifu_dec_stall}, 32'd0);
      chk("rst.rdata_2", reg_rdata_2, 32'd0);
      @(negedge hclk);
      hrstn = 1'b1;

      regs[1] = 32'd5;
      set_op(OpAddi, 5'd1, 5'd0, 5'd2, 32'h0); imm_i = 12'd7;
      run_instr("addi", ex_wb(5'd2, 32'd12), 1'b0);

      regs[1] = 32'hFFFFFFFF; regs[2] = 32'd1;
      set_op(OpSltu, 5'd1, 5'd2, 5'd3, 32'h0);
      run_instr("sltu", ex_wb(5'd3, 32'd0), 1'b0);
      set_op(OpSlt, 5'd1, 5'd2, 5'd3, 32'h0);
      run_instr("slt", ex_wb(5'd3, 32'd1), 1'b0);
      set_op(OpSub, 5'd1, 5'd2, 5'd3, 32'h0);
      run_instr("sub", ex_wb(5'd3, 32'hFFFFFFFE), 1'b0);

      regs[10] = 32'h80000000;
      set_op(OpSrai, 5'd10, 5'd0, 5'd4, 32'h0); imm_i = 12'h404;
      run_instr("srai", ex_wb(5'd4, 32'hF8000000), 1'b0);
      regs[11] = 32'd33;
      set_op(OpSll, 5'd2, 5'd11, 5'd4, 32'h0);
      run_instr("sll", ex_wb(5'd4, 32'd2), 1'b0);

      regs[1] = 32'd3; regs[2] = 32'd3;
      set_op(OpBeq, 5'd1, 5'd2, 5'd0, 32'h100); imm_b = 13'h1FF8;
      run_instr("beq", ex_pc(32'hF8), 1'b0);
      set_op(OpBne, 5'd1, 5'd2, 5'd0, 32'h100); imm_b = 13'h1FF8;
      run_instr("bne", ex_none(), 1'b0);
      regs[5] = 32'hFFFFFFFF; regs[6] = 32'd1;
      set_op(OpBlt, 5'd5, 5'd6, 5'd0, 32'h100); imm_b = 13'd16;
      run_instr("blt", ex_pc(32'h110), 1'b0);
      set_op(OpBltu, 5'd5, 5'd6, 5'd0, 32'h100); imm_b = 13'd16;
      run_instr("bltu", ex_none(), 1'b0);

      set_op(OpJal, 5'd0, 5'd0, 5'd1, 32'h40); imm_j = 21'h20;
      e = ex_wb(5'd1, 32'h44); e.pcw = 1'b1; e.pcd = 32'h60;
      run_instr("jal", e, 1'b0);
      regs[5] = 32'h101;
      set_op(OpJalr, 5'd5, 5'd0, 5'd1, 32'h40);
      e = ex_wb(5'd1, 32'h44); e.pcw = 1'b1; e.pcd = 32'h100;
      run_instr("jalr", e, 1'b0);

      set_op(OpLui, 5'd0, 5'd0, 5'd7, 32'h0); imm_u = 20'h12345;
      run_instr("lui", ex_wb(5'd7, 32'h12345000), 1'b0);
      set_op(OpAuipc, 5'd0, 5'd0, 5'd8, 32'h200); imm_u = 20'h1;
      run_instr("auipc", ex_wb(5'd8, 32'h1200), 1'b0);

      regs[1] = 32'h1000; regs[2] = 32'hCAFEF00D;
      set_op(OpLh, 5'd1, 5'd0, 5'd5, 32'h0); imm_i = 12'hFFE;
      e = ex_none(); e.ld_en = 1'b1; e.ld_rd = 5'd5; e.ld_base = 32'h1000;
      e.ld_off = 32'hFFFFFFFE; e.ld_sext = 1'b1; e.ld_size = 2'd1;
      run_instr("lh", e, 1'b0);
      set_op(OpLbu, 5'd1, 5'd0, 5'd6, 32'h0); imm_i = 12'd3;
      e = ex_none(); e.ld_en = 1'b1; e.ld_rd = 5'd6; e.ld_base = 32'h1000;
      e.ld_off = 32'd3; e.ld_sext = 1'b0; e.ld_size = 2'd0;
      run_instr("lbu", e, 1'b0);
      set_op(OpSw, 5'd1, 5'd2, 5'd0, 32'h0); imm_s = 12'd4;
      e = ex_none(); e.st_en = 1'b1; e.st_addr = 32'h1004; e.st_data = 32'hCAFEF00D;
      e.st_size = 2'd2;
      run_instr("sw", e, 1'b0);
      set_op(OpSb, 5'd1, 5'd2, 5'd0, 32'h0); imm_s = 12'hFFF;
      e = ex_none(); e.st_en = 1'b1; e.st_addr = 32'hFFF; e.st_data = 32'hCAFEF00D;
      e.st_size = 2'd0;
      run_instr("sb", e, 1'b0);

      set_op(OpAddi, 5'd0, 5'd0, 5'd0, 32'h0); imm_i = 12'd1;
      run_instr("addi_x0", ex_none(), 1'b0);
      set_op(OpEcall, 5'd0, 5'd0, 5'd0, 32'h0);
      run_instr("ecall", ex_none(), 1'b0);

      set_op(OpAddi, 5'd1, 5'd0, 5'd2, 32'h0); imm_i = 12'd7;
      run_instr("mid_reset", ex_none(), 1'b1);
      set_op(OpAddi, 5'd1, 5'd0, 5'd9, 32'h0); imm_i = 12'd1;
      run_instr("after_reset", ex_wb(5'd9, 32'h1001), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
